// File: rtl/tty_writer_pkg.sv
// ---------------------------------------------------------------------------
// tty_writer_pkg
// Shared constants, state encoding and helpers for the text console writer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tty_writer_pkg;

  // Control codes recognised by the writer
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Fill byte used for screen/line clears and backspace erase
  localparam logic [7:0] BLANK = 8'h20;

  // Default text geometry
  localparam int DEF_COLS = 32;
  localparam int DEF_ROWS = 30;

  // Writer states
  typedef enum logic [1:0] {
    ST_INIT_CLR = 2'd0,
    ST_IDLE     = 2'd1,
    ST_CLR_ALL  = 2'd2,
    ST_CLR_LINE = 2'd3
  } tty_state_t;

  // True for bytes that are drawn as glyphs (space through tilde)
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tty_writer_vm_addr_gen.sv
// ---------------------------------------------------------------------------
// vm_addr_gen
// Maps a (row, col) text position to the 12-bit video memory address.
// Shared with the display-side read address so both agree on the layout.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vm_addr_gen
  import tty_writer_pkg::*;
(
  input  logic [4:0]  i_row,
  input  logic [4:0]  i_col,
  output logic [11:0] o_addr
);

  // Row in bits [9:5], column in bits [4:0]; top two bits unused by text RAM
  assign o_addr = {2'b00, i_row, i_col};

endmodule

`default_nettype wire

// File: rtl/tty_writer.sv
// ---------------------------------------------------------------------------
// tty_writer
// Character-stream front end for text-mode video memory: accepts ASCII bytes,
// tracks a cursor, interprets CR/LF/BS/FF and issues single-cycle VM writes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tty_writer
  import tty_writer_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = tty_writer_pkg::BLANK
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic        clr,
  output logic        vm_we,
  output logic [11:0] vm_addr,
  output logic [7:0]  vm_din,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col,
  output logic        busy
);

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  // Registered state and outputs
  tty_state_t  r_state;
  logic [4:0]  r_clr_row;
  logic [4:0]  r_clr_col;
  logic [4:0]  r_row;
  logic [4:0]  r_col;
  logic        r_we;
  logic [11:0] r_addr;
  logic [7:0]  r_din;
  logic        r_ready;
  logic        r_busy;

  // Next-state values
  tty_state_t  w_nxt_state;
  logic [4:0]  w_nxt_clr_row;
  logic [4:0]  w_nxt_clr_col;
  logic [4:0]  w_nxt_row;
  logic [4:0]  w_nxt_col;
  logic        w_nxt_we;
  logic [7:0]  w_nxt_din;
  logic        w_nxt_idle;

  // Write position fed to the address mapper
  logic [4:0]  w_gen_row;
  logic [4:0]  w_gen_col;
  logic [11:0] w_gen_addr;

  // Row advance wraps at the bottom instead of scrolling
  function automatic logic [4:0] adv_row(input logic [4:0] row);
    return (row == ROW_LAST) ? 5'd0 : row + 5'd1;
  endfunction

  vm_addr_gen u_addr_gen (
    .i_row  (w_gen_row),
    .i_col  (w_gen_col),
    .o_addr (w_gen_addr)
  );

  // Next-state, cursor and write-request decode
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_clr_row = r_clr_row;
    w_nxt_clr_col = r_clr_col;
    w_nxt_row     = r_row;
    w_nxt_col     = r_col;
    w_nxt_we      = 1'b0;
    w_nxt_din     = BLANK;
    w_gen_row     = r_row;
    w_gen_col     = r_col;

    unique case (r_state)
      ST_INIT_CLR, ST_CLR_ALL: begin
        // A fresh clear request restarts a user clear; the power-on clear ignores it
        if (clr && (r_state == ST_CLR_ALL)) begin
          w_nxt_clr_row = 5'd0;
          w_nxt_clr_col = 5'd0;
        end else begin
          w_nxt_we  = 1'b1;
          w_gen_row = r_clr_row;
          w_gen_col = r_clr_col;
          if (r_clr_col == COL_LAST) begin
            w_nxt_clr_col = 5'd0;
            if (r_clr_row == ROW_LAST) begin
              w_nxt_clr_row = 5'd0;
              w_nxt_row     = 5'd0;
              w_nxt_col     = 5'd0;
              w_nxt_state   = ST_IDLE;
            end else begin
              w_nxt_clr_row = r_clr_row + 5'd1;
            end
          end else begin
            w_nxt_clr_col = r_clr_col + 5'd1;
          end
        end
      end

      ST_CLR_LINE: begin
        if (clr) begin
          w_nxt_clr_row = 5'd0;
          w_nxt_clr_col = 5'd0;
          w_nxt_state   = ST_CLR_ALL;
        end else begin
          // Cursor already sits at (new row, 0); blank that row left to right
          w_nxt_we  = 1'b1;
          w_gen_row = r_row;
          w_gen_col = r_clr_col;
          if (r_clr_col == COL_LAST) begin
            w_nxt_clr_col = 5'd0;
            w_nxt_state   = ST_IDLE;
          end else begin
            w_nxt_clr_col = r_clr_col + 5'd1;
          end
        end
      end

      ST_IDLE: begin
        if (clr) begin
          // Clear wins over a simultaneous byte; the byte stays unaccepted
          w_nxt_clr_row = 5'd0;
          w_nxt_clr_col = 5'd0;
          w_nxt_state   = ST_CLR_ALL;
        end else if (ch_valid) begin
          if (is_printable(ch_data)) begin
            w_nxt_we  = 1'b1;
            w_nxt_din = ch_data;
            if (r_col == COL_LAST) begin
              w_nxt_col     = 5'd0;
              w_nxt_row     = adv_row(r_row);
              w_nxt_clr_col = 5'd0;
              w_nxt_state   = ST_CLR_LINE;
            end else begin
              w_nxt_col = r_col + 5'd1;
            end
          end else begin
            unique case (ch_data)
              CH_LF: begin
                w_nxt_col     = 5'd0;
                w_nxt_row     = adv_row(r_row);
                w_nxt_clr_col = 5'd0;
                w_nxt_state   = ST_CLR_LINE;
              end
              CH_CR: begin
                w_nxt_col = 5'd0;
              end
              CH_BS: begin
                // No reverse wrap onto the previous row
                if (r_col != 5'd0) begin
                  w_nxt_col = r_col - 5'd1;
                  w_nxt_we  = 1'b1;
                  w_gen_col = r_col - 5'd1;
                end
              end
              CH_FF: begin
                w_nxt_clr_row = 5'd0;
                w_nxt_clr_col = 5'd0;
                w_nxt_state   = ST_CLR_ALL;
              end
              default: begin
                // Unrecognised control byte: consumed silently
              end
            endcase
          end
        end
      end

      default: begin
        w_nxt_state = ST_INIT_CLR;
      end
    endcase
  end

  assign w_nxt_idle = (w_nxt_state == ST_IDLE);

  // State register and registered outputs; address/data hold between writes
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_INIT_CLR;
      r_clr_row <= 5'd0;
      r_clr_col <= 5'd0;
      r_row     <= 5'd0;
      r_col     <= 5'd0;
      r_we      <= 1'b0;
      r_addr    <= 12'd0;
      r_din     <= 8'd0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_clr_row <= w_nxt_clr_row;
      r_clr_col <= w_nxt_clr_col;
      r_row     <= w_nxt_row;
      r_col     <= w_nxt_col;
      r_we      <= w_nxt_we;
      if (w_nxt_we) begin
        r_addr <= w_gen_addr;
        r_din  <= w_nxt_din;
      end
      r_ready   <= w_nxt_idle;
      r_busy    <= ~w_nxt_idle;
    end
  end

  assign ch_ready = r_ready;
  assign busy     = r_busy;
  assign vm_we    = r_we;
  assign vm_addr  = r_addr;
  assign vm_din   = r_din;
  assign cur_row  = r_row;
  assign cur_col  = r_col;

endmodule

`default_nettype wire

// File: tb/tb_tty_writer.sv
// ---------------------------------------------------------------------------
// tb_tty_writer
// Directed self-checking bench for tty_writer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tty_writer;

  logic        clk_50mhz = 1'b0;
  logic        rst       = 1'b0;
  logic [7:0]  ch_data   = 8'h00;
  logic        ch_valid  = 1'b0;
  logic        clr       = 1'b0;
  logic        ch_ready;
  logic        vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_din;
  logic [4:0]  cur_row;
  logic [4:0]  cur_col;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  tty_writer dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .clr       (clr),
    .vm_we     (vm_we),
    .vm_addr   (vm_addr),
    .vm_din    (vm_din),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct {
    logic [7:0]  data;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_din;
    logic [4:0]  exp_row;
    logic [4:0]  exp_col;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ch_data  = b;
    ch_valid = 1'b1;
    step();
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (ch_ready !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    chk(name, {31'd0, ch_ready}, 32'd1);
  endtask

  // Expects n consecutive BLANK writes from base upward, allowing up to
  // maxwait idle cycles before the first one, then a quiet cycle after.
  task automatic clear_check(input string name, input int base, input int n,
                             input int maxwait, output int low_cnt);
    int w;
    int bad;
    int bad_k;
    logic        bw;
    logic [11:0] ba;
    logic [7:0]  bd;
    w = 0; bad = 0; bad_k = -1; bw = 1'b0; ba = '0; bd = '0;
    low_cnt = 0;
    while (vm_we !== 1'b1 && w < maxwait) begin
      step();
      w++;
    end
    for (int k = 0; k < n; k++) begin
      if (vm_we !== 1'b1 || vm_addr !== 12'(base + k) || vm_din !== 8'h20) begin
        if (bad == 0) begin
          bad_k = k; bw = vm_we; ba = vm_addr; bd = vm_din;
        end
        bad++;
      end
      if (ch_ready === 1'b0) low_cnt++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s: %0d bad writes, first idx %0d got we=%b addr=0x%h din=0x%h expected we=1 addr=0x%h din=0x20",
               name, bad, bad_k, bw, ba, bd, 12'(base + bad_k));
    end
    chk({name, "_end_we"}, {31'd0, vm_we}, 32'd0);
  endtask

  initial begin
    int lc;
    int low;

    vecs[0]  = '{8'h41, 1'b1, 12'h000, 8'h41, 5'd0, 5'd1};
    vecs[1]  = '{8'h42, 1'b1, 12'h001, 8'h42, 5'd0, 5'd2};
    vecs[2]  = '{8'h43, 1'b1, 12'h002, 8'h43, 5'd0, 5'd3};
    vecs[3]  = '{8'h08, 1'b1, 12'h002, 8'h20, 5'd0, 5'd2};
    vecs[4]  = '{8'h01, 1'b0, 12'h000, 8'h00, 5'd0, 5'd2};
    vecs[5]  = '{8'h78, 1'b1, 12'h002, 8'h78, 5'd0, 5'd3};
    vecs[6]  = '{8'h7E, 1'b1, 12'h003, 8'h7E, 5'd0, 5'd4};
    vecs[7]  = '{8'h7F, 1'b0, 12'h000, 8'h00, 5'd0, 5'd4};
    vecs[8]  = '{8'h0D, 1'b0, 12'h000, 8'h00, 5'd0, 5'd0};
    vecs[9]  = '{8'h08, 1'b0, 12'h000, 8'h00, 5'd0, 5'd0};
    vecs[10] = '{8'h20, 1'b1, 12'h000, 8'h20, 5'd0, 5'd1};

    // Reset values while held in reset
    repeat (3) step();
    chk("rst_we",    {31'd0, vm_we},    32'd0);
    chk("rst_addr",  {20'd0, vm_addr},  32'd0);
    chk("rst_din",   {24'd0, vm_din},   32'd0);
    chk("rst_row",   {27'd0, cur_row},  32'd0);
    chk("rst_col",   {27'd0, cur_col},  32'd0);
    chk("rst_ready", {31'd0, ch_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd1);

    // Power-on clear of the whole screen
    @(negedge clk_50mhz);
    rst = 1'b1;
    clear_check("init_clear", 0, 960, 4, lc);
    chk("init_ready", {31'd0, ch_ready}, 32'd1);
    chk("init_busy",  {31'd0, busy},     32'd0);
    chk("init_row",   {27'd0, cur_row},  32'd0);
    chk("init_col",   {27'd0, cur_col},  32'd0);

    // Single-cycle byte handling from the table
    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].data);
      chk($sformatf("vec%0d_we", i), {31'd0, vm_we}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_addr", i), {20'd0, vm_addr}, {20'd0, vecs[i].exp_addr});
        chk($sformatf("vec%0d_din", i),  {24'd0, vm_din},  {24'd0, vecs[i].exp_din});
      end
      chk($sformatf("vec%0d_row", i),   {27'd0, cur_row},  {27'd0, vecs[i].exp_row});
      chk($sformatf("vec%0d_col", i),   {27'd0, cur_col},  {27'd0, vecs[i].exp_col});
      chk($sformatf("vec%0d_ready", i), {31'd0, ch_ready}, 32'd1);
    end

    // CR at column 7
    for (int i = 0; i < 6; i++) send_byte(8'h63);
    chk("cr_pre_col", {27'd0, cur_col}, 32'd7);
    send_byte(8'h0D);
    chk("cr_we",  {31'd0, vm_we},   32'd0);
    chk("cr_col", {27'd0, cur_col}, 32'd0);

    // Printable at the last column: write, then line clear of row 1
    for (int i = 0; i < 31; i++) send_byte(8'h61);
    chk("z_pre_col", {27'd0, cur_col}, 32'd31);
    send_byte(8'h5A);
    chk("z_we",    {31'd0, vm_we},   32'd1);
    chk("z_addr",  {20'd0, vm_addr}, 32'h01F);
    chk("z_din",   {24'd0, vm_din},  32'h5A);
    chk("z_row",   {27'd0, cur_row}, 32'd1);
    chk("z_col",   {27'd0, cur_col}, 32'd0);
    low = (ch_ready === 1'b0) ? 1 : 0;
    step();
    clear_check("z_line", 32'h020, 32, 0, lc);
    chk("z_ready_low", low + lc, 32'd32);
    chk("z_ready", {31'd0, ch_ready}, 32'd1);

    // Walk down to row 29, column 5, then LF wraps to row 0
    for (int i = 0; i < 28; i++) begin
      send_byte(8'h0A);
      wait_idle("lf_walk_idle", 40);
    end
    for (int i = 0; i < 5; i++) send_byte(8'h62);
    chk("wrap_pre_row", {27'd0, cur_row}, 32'd29);
    chk("wrap_pre_col", {27'd0, cur_col}, 32'd5);
    send_byte(8'h0A);
    chk("wrap_we",    {31'd0, vm_we},    32'd0);
    chk("wrap_row",   {27'd0, cur_row},  32'd0);
    chk("wrap_col",   {27'd0, cur_col},  32'd0);
    chk("wrap_ready", {31'd0, ch_ready}, 32'd0);
    clear_check("wrap_line", 32'h000, 32, 3, lc);
    chk("wrap_idle", {31'd0, ch_ready}, 32'd1);

    // Backspace at column 0 of row 3, then at column 4
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h0A);
      wait_idle("lf_row3_idle", 40);
    end
    send_byte(8'h08);
    chk("bs0_we",  {31'd0, vm_we},   32'd0);
    chk("bs0_row", {27'd0, cur_row}, 32'd3);
    chk("bs0_col", {27'd0, cur_col}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h64);
    send_byte(8'h08);
    chk("bs4_we",   {31'd0, vm_we},   32'd1);
    chk("bs4_addr", {20'd0, vm_addr}, 32'h063);
    chk("bs4_din",  {24'd0, vm_din},  32'h20);
    chk("bs4_row",  {27'd0, cur_row}, 32'd3);
    chk("bs4_col",  {27'd0, cur_col}, 32'd3);

    // clr and a byte together: clear wins, 'Q' never written
    ch_data  = 8'h51;
    ch_valid = 1'b1;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    ch_valid = 1'b0;
    chk("clrq_we",    {31'd0, vm_we},    32'd0);
    chk("clrq_ready", {31'd0, ch_ready}, 32'd0);
    chk("clrq_busy",  {31'd0, busy},     32'd1);
    clear_check("clrq_clear", 0, 960, 3, lc);
    chk("clrq_row",  {27'd0, cur_row},  32'd0);
    chk("clrq_col",  {27'd0, cur_col},  32'd0);
    chk("clrq_idle", {31'd0, ch_ready}, 32'd1);

    // Form feed clears the screen and homes the cursor
    send_byte(8'h41);
    send_byte(8'h0C);
    chk("ff_we", {31'd0, vm_we}, 32'd0);
    clear_check("ff_clear", 0, 960, 3, lc);
    chk("ff_row", {27'd0, cur_row}, 32'd0);
    chk("ff_col", {27'd0, cur_col}, 32'd0);

    // clr during a line clear restarts a full clear from address 0
    send_byte(8'h0A);
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clrline_we", {31'd0, vm_we}, 32'd0);
    clear_check("clrline_clear", 0, 960, 3, lc);
    chk("clrline_row", {27'd0, cur_row}, 32'd0);

    // Reset asserted mid line clear
    send_byte(8'h0A);
    repeat (5) step();
    chk("mid_we_before", {31'd0, vm_we}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_we",    {31'd0, vm_we},    32'd0);
    chk("mid_rst_busy",  {31'd0, busy},     32'd1);
    chk("mid_rst_ready", {31'd0, ch_ready}, 32'd0);
    chk("mid_rst_row",   {27'd0, cur_row},  32'd0);
    @(negedge clk_50mhz);
    rst = 1'b1;
    clear_check("reinit_clear", 0, 960, 4, lc);
    chk("reinit_ready", {31'd0, ch_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
